alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter_pkg.sv | 39 +++
 rtl/alu_arbiter_if.sv | 63 ++++++
 rtl/alu_arbiter_rr_arbiter2.sv | 19 +
 rtl/alu_arbiter.sv | 113 +++++++++++
 tb/tb_alu_arbiter.sv | 286 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_arbiter_pkg.sv
// Shared types and constants for the two-requester ALU arbiter.
package alu_arbiter_pkg;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned OPC_W   = 5;
  localparam int unsigned SHAMT_W = 5;

  // Arbiter FSM encoding
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_RESP = 2'b10
  } state_e;

  // ALU opcodes, passed through to the shared ALU untouched
  localparam logic [OPC_W-1:0] OPC_ADD = 5'b00000;
  localparam logic [OPC_W-1:0] OPC_SUB = 5'b00001;
  localparam logic [OPC_W-1:0] OPC_AND = 5'b00010;
  localparam logic [OPC_W-1:0] OPC_OR  = 5'b00011;
  localparam logic [OPC_W-1:0] OPC_SLL = 5'b00100;
  localparam logic [OPC_W-1:0] OPC_SRA = 5'b00101;

  // Operation latched from the granted requester
  typedef struct packed {
    logic [DATA_W-1:0]  op_a;
    logic [DATA_W-1:0]  op_b;
    logic [OPC_W-1:0]   opcode;
    logic [SHAMT_W-1:0] shamt;
  } alu_req_t;

  // Result and flags captured from the ALU
  typedef struct packed {
    logic [DATA_W-1:0] result;
    logic              neq;
    logic              lt;
    logic              ovf;
  } alu_resp_t;

endpackage

// File: rtl/alu_arbiter_if.sv
// Bus bundle between two requesters, the arbiter and the shared ALU.
// slave  : arbiter side (takes requests, returns responses, drives the ALU)
// master : environment side (requesters and the ALU itself)
interface alu_arbiter_if;
  import alu_arbiter_pkg::*;

  // Requester 0
  logic                req_valid_0;
  logic                req_ready_0;
  logic [DATA_W-1:0]   req_opA_0;
  logic [DATA_W-1:0]   req_opB_0;
  logic [OPC_W-1:0]    req_opcode_0;
  logic [SHAMT_W-1:0]  req_shamt_0;
  logic                resp_valid_0;
  logic                resp_ready_0;
  logic [DATA_W-1:0]   resp_result_0;
  logic                resp_neq_0;
  logic                resp_lt_0;
  logic                resp_ovf_0;

  // Requester 1
  logic                req_valid_1;
  logic                req_ready_1;
  logic [DATA_W-1:0]   req_opA_1;
  logic [DATA_W-1:0]   req_opB_1;
  logic [OPC_W-1:0]    req_opcode_1;
  logic [SHAMT_W-1:0]  req_shamt_1;
  logic                resp_valid_1;
  logic                resp_ready_1;
  logic [DATA_W-1:0]   resp_result_1;
  logic                resp_neq_1;
  logic                resp_lt_1;
  logic                resp_ovf_1;

  // Shared ALU
  logic [DATA_W-1:0]   alu_operandA;
  logic [DATA_W-1:0]   alu_operandB;
  logic [OPC_W-1:0]    alu_opcode;
  logic [SHAMT_W-1:0]  alu_shiftamt;
  logic [DATA_W-1:0]   alu_result;
  logic                alu_isNotEqual;
  logic                alu_isLessThan;
  logic                alu_overflow;

  modport slave (
    input  req_valid_0, req_opA_0, req_opB_0, req_opcode_0, req_shamt_0, resp_ready_0,
    output req_ready_0, resp_valid_0, resp_result_0, resp_neq_0, resp_lt_0, resp_ovf_0,
    input  req_valid_1, req_opA_1, req_opB_1, req_opcode_1, req_shamt_1, resp_ready_1,
    output req_ready_1, resp_valid_1, resp_result_1, resp_neq_1, resp_lt_1, resp_ovf_1,
    output alu_operandA, alu_operandB, alu_opcode, alu_shiftamt,
    input  alu_result, alu_isNotEqual, alu_isLessThan, alu_overflow
  );

  modport master (
    output req_valid_0, req_opA_0, req_opB_0, req_opcode_0, req_shamt_0, resp_ready_0,
    input  req_ready_0, resp_valid_0, resp_result_0, resp_neq_0, resp_lt_0, resp_ovf_0,
    output req_valid_1, req_opA_1, req_opB_1, req_opcode_1, req_shamt_1, resp_ready_1,
    input  req_ready_1, resp_valid_1, resp_result_1, resp_neq_1, resp_lt_1, resp_ovf_1,
    input  alu_operandA, alu_operandB, alu_opcode, alu_shiftamt,
    output alu_result, alu_isNotEqual, alu_isLessThan, alu_overflow
  );

endinterface

// File: rtl/alu_arbiter_rr_arbiter2.sv
// Two-way round-robin grant.
// valid : request lines {1,0}
// last  : id of the requester granted most recently
// grant : one-hot grant (zero when nothing is valid)
module rr_arbiter2 (
  input  logic [1:0] valid,
  input  logic       last,
  output logic [1:0] grant
);

  // A lone requester always wins; on contention the one not served last wins
  always_comb begin
    grant = valid;
    if (valid == 2'b11) begin
      grant = last ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Arbitrates two requesters onto one shared combinational ALU, one
// operation in flight at a time (IDLE -> EXEC -> RESP).
// clock : rising-edge clock
// reset : synchronous active-high reset
// bus   : requester handshakes, broadcast response, shared-ALU port
module alu_arbiter
  import alu_arbiter_pkg::*;
(
  input  logic          clock,
  input  logic          reset,
  alu_arbiter_if.slave  bus
);

  state_e     state_q;
  logic       owner_q;
  logic       last_q;
  alu_req_t   req_q;
  alu_resp_t  resp_q;
  logic [1:0] resp_valid_q;

  logic [1:0] valid;
  logic [1:0] grant;
  alu_req_t   req_sel;
  alu_resp_t  alu_resp;
  logic       resp_ready_sel;

  assign valid = {bus.req_valid_1, bus.req_valid_0};

  rr_arbiter2 u_rr (
    .valid (valid),
    .last  (last_q),
    .grant (grant)
  );

  // Operation of the granted requester
  always_comb begin
    req_sel = '{op_a: bus.req_opA_0, op_b: bus.req_opB_0,
                opcode: bus.req_opcode_0, shamt: bus.req_shamt_0};
    if (grant[1]) begin
      req_sel = '{op_a: bus.req_opA_1, op_b: bus.req_opB_1,
                  opcode: bus.req_opcode_1, shamt: bus.req_shamt_1};
    end
  end

  // Acceptance is combinational and only possible in IDLE outside reset
  always_comb begin
    bus.req_ready_0 = 1'b0;
    bus.req_ready_1 = 1'b0;
    if (state_q == ST_IDLE && !reset) begin
      bus.req_ready_0 = grant[0];
      bus.req_ready_1 = grant[1];
    end
  end

  assign alu_resp = '{result: bus.alu_result, neq: bus.alu_isNotEqual,
                      lt: bus.alu_isLessThan, ovf: bus.alu_overflow};

  assign resp_ready_sel = owner_q ? bus.resp_ready_1 : bus.resp_ready_0;

  // FSM, operand latch and response capture
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      owner_q      <= 1'b0;
      last_q       <= 1'b1;
      req_q        <= '0;
      resp_q       <= '0;
      resp_valid_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (|grant) begin
            owner_q <= grant[1];
            req_q   <= req_sel;
            state_q <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          resp_q       <= alu_resp;
          resp_valid_q <= owner_q ? 2'b10 : 2'b01;
          state_q      <= ST_RESP;
        end
        ST_RESP: begin
          if (resp_ready_sel) begin
            resp_valid_q <= '0;
            last_q       <= owner_q;
            state_q      <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // ALU inputs come straight from the latch, so they hold outside EXEC
  assign bus.alu_operandA = req_q.op_a;
  assign bus.alu_operandB = req_q.op_b;
  assign bus.alu_opcode   = req_q.opcode;
  assign bus.alu_shiftamt = req_q.shamt;

  // Response data is broadcast; only resp_valid_n qualifies it
  assign bus.resp_valid_0  = resp_valid_q[0];
  assign bus.resp_valid_1  = resp_valid_q[1];
  assign bus.resp_result_0 = resp_q.result;
  assign bus.resp_neq_0    = resp_q.neq;
  assign bus.resp_lt_0     = resp_q.lt;
  assign bus.resp_ovf_0    = resp_q.ovf;
  assign bus.resp_result_1 = resp_q.result;
  assign bus.resp_neq_1    = resp_q.neq;
  assign bus.resp_lt_1     = resp_q.lt;
  assign bus.resp_ovf_1    = resp_q.ovf;

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter with a behavioural shared ALU.
module tb_alu_arbiter;
  import alu_arbiter_pkg::*;

  typedef struct {
    int          id;
    logic [31:0] res;
    logic        neq;
    logic        lt;
    logic        ovf;
  } exp_t;

  logic clk;
  logic reset;
  int   compared;
  int   errors;
  exp_t exp_q[$];

  alu_arbiter_if bus();

  alu_arbiter dut (
    .clock (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural shared ALU; lt is only meaningful for SUB
  logic [31:0] alu_a, alu_b, alu_sum, alu_diff;
  always_comb begin
    alu_a    = bus.alu_operandA;
    alu_b    = bus.alu_operandB;
    alu_sum  = alu_a + alu_b;
    alu_diff = alu_a - alu_b;
    bus.alu_result     = 32'h0;
    bus.alu_overflow   = 1'b0;
    bus.alu_isLessThan = 1'b0;
    bus.alu_isNotEqual = (alu_a != alu_b);
    case (bus.alu_opcode)
      OPC_ADD: begin
        bus.alu_result   = alu_sum;
        bus.alu_overflow = (alu_a[31] == alu_b[31]) && (alu_sum[31] != alu_a[31]);
      end
      OPC_SUB: begin
        bus.alu_result     = alu_diff;
        bus.alu_overflow   = (alu_a[31] != alu_b[31]) && (alu_diff[31] != alu_a[31]);
        bus.alu_isLessThan = alu_diff[31] ^ bus.alu_overflow;
      end
      OPC_AND: bus.alu_result = alu_a & alu_b;
      OPC_OR:  bus.alu_result = alu_a | alu_b;
      OPC_SLL: bus.alu_result = alu_a << bus.alu_shiftamt;
      OPC_SRA: bus.alu_result = 32'($signed(alu_a) >>> bus.alu_shiftamt);
      default: bus.alu_result = 32'h0;
    endcase
  end

  // Monitor: every response handshake pops and checks the oldest expectation
  always @(negedge clk) begin
    if (reset === 1'b0) begin
      for (int n = 0; n < 2; n++) begin
        logic        v, r, neq, lt, ovf, other_v;
        logic [31:0] res;
        exp_t        e;
        v       = (n == 0) ? bus.resp_valid_0  : bus.resp_valid_1;
        r       = (n == 0) ? bus.resp_ready_0  : bus.resp_ready_1;
        res     = (n == 0) ? bus.resp_result_0 : bus.resp_result_1;
        neq     = (n == 0) ? bus.resp_neq_0    : bus.resp_neq_1;
        lt      = (n == 0) ? bus.resp_lt_0     : bus.resp_lt_1;
        ovf     = (n == 0) ? bus.resp_ovf_0    : bus.resp_ovf_1;
        other_v = (n == 0) ? bus.resp_valid_1  : bus.resp_valid_0;
        if (v === 1'b1 && r === 1'b1) begin
          compared++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_resp: requester %0d result=%h with nothing expected", n, res);
          end else begin
            e = exp_q.pop_front();
            if (e.id != n || res !== e.res || neq !== e.neq || lt !== e.lt ||
                ovf !== e.ovf || other_v !== 1'b0) begin
              errors++;
              $display("FAIL resp: got id=%0d res=%h neq=%b lt=%b ovf=%b other_valid=%b, expected id=%0d res=%h neq=%b lt=%b ovf=%b other_valid=0",
                       n, res, neq, lt, ovf, other_v, e.id, e.res, e.neq, e.lt, e.ovf);
            end
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic expect_resp(input int id, input logic [31:0] res,
                             input logic neq, input logic lt, input logic ovf);
    exp_t e;
    e.id = id; e.res = res; e.neq = neq; e.lt = lt; e.ovf = ovf;
    exp_q.push_back(e);
  endtask

  // Present an operation, wait (bounded) for acceptance, then withdraw it
  task automatic send(input int id, input logic [31:0] a, input logic [31:0] b,
                      input logic [4:0] op, input logic [4:0] sh);
    bit ok;
    if (id == 0) begin
      bus.req_opA_0 = a; bus.req_opB_0 = b; bus.req_opcode_0 = op;
      bus.req_shamt_0 = sh; bus.req_valid_0 = 1'b1;
    end else begin
      bus.req_opA_1 = a; bus.req_opB_1 = b; bus.req_opcode_1 = op;
      bus.req_shamt_1 = sh; bus.req_valid_1 = 1'b1;
    end
    ok = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if ((id == 0 && bus.req_ready_0 === 1'b1) || (id == 1 && bus.req_ready_1 === 1'b1)) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      compared++;
      errors++;
      $display("FAIL accept_timeout: requester %0d never accepted", id);
    end
    @(posedge clk); #1;
    if (id == 0) bus.req_valid_0 = 1'b0;
    else         bus.req_valid_1 = 1'b0;
  endtask

  task automatic wait_drain();
    bit ok;
    ok = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      compared++;
      errors++;
      $display("FAIL drain_timeout: %0d responses outstanding", exp_q.size());
      exp_q.delete();
    end
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  initial begin
    compared = 0;
    errors   = 0;
    reset    = 1'b1;
    bus.req_valid_0 = 1'b1; bus.req_opA_0 = '0; bus.req_opB_0 = '0;
    bus.req_opcode_0 = '0; bus.req_shamt_0 = '0; bus.resp_ready_0 = 1'b1;
    bus.req_valid_1 = 1'b1; bus.req_opA_1 = '0; bus.req_opB_1 = '0;
    bus.req_opcode_1 = '0; bus.req_shamt_1 = '0; bus.resp_ready_1 = 1'b1;

    // Reset state, with both requests asserted during reset
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready_0", 32'(bus.req_ready_0), 32'd0);
    chk("rst_ready_1", 32'(bus.req_ready_1), 32'd0);
    chk("rst_resp_valid_0", 32'(bus.resp_valid_0), 32'd0);
    chk("rst_resp_valid_1", 32'(bus.resp_valid_1), 32'd0);
    chk("rst_alu_operandA", bus.alu_operandA, 32'h0);
    chk("rst_resp_result", bus.resp_result_0, 32'h0);
    bus.req_valid_0 = 1'b0;
    bus.req_valid_1 = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;

    // Both requesters contend continuously: 0,1,0,1
    expect_resp(0, 32'd3, 1'b1, 1'b0, 1'b0);
    expect_resp(1, 32'd6, 1'b1, 1'b0, 1'b0);
    expect_resp(0, 32'hFF, 1'b1, 1'b0, 1'b0);
    expect_resp(1, 32'hFFFF_FFFA, 1'b1, 1'b1, 1'b0);
    fork
      begin
        send(0, 32'd1, 32'd2, OPC_ADD, 5'd0);
        send(0, 32'h0F, 32'hF0, OPC_OR, 5'd0);
      end
      begin
        send(1, 32'd10, 32'd4, OPC_SUB, 5'd0);
        send(1, 32'd4, 32'd10, OPC_SUB, 5'd0);
      end
    join
    wait_drain();

    // Single ADD with latency check
    expect_resp(0, 32'd12, 1'b1, 1'b0, 1'b0);
    send(0, 32'd5, 32'd7, OPC_ADD, 5'd0);
    @(negedge clk);
    chk("lat_exec_resp_valid_0", 32'(bus.resp_valid_0), 32'd0);
    @(negedge clk);
    chk("lat_n2_resp_valid_0", 32'(bus.resp_valid_0), 32'd1);
    chk("lat_n2_resp_valid_1", 32'(bus.resp_valid_1), 32'd0);
    wait_drain();

    // SUB overflow and equality on requester 1
    expect_resp(1, 32'h8000_0000, 1'b1, 1'b0, 1'b1);
    send(1, 32'h7FFF_FFFF, 32'hFFFF_FFFF, OPC_SUB, 5'd0);
    wait_drain();
    expect_resp(1, 32'h0, 1'b0, 1'b0, 1'b0);
    send(1, 32'd3, 32'd3, OPC_SUB, 5'd0);
    wait_drain();

    // Remaining opcodes and an unsupported one
    expect_resp(0, 32'hF000, 1'b1, 1'b0, 1'b0);
    send(0, 32'hF0F0, 32'hFF00, OPC_AND, 5'd0);
    wait_drain();
    expect_resp(0, 32'hFFF0, 1'b1, 1'b0, 1'b0);
    send(0, 32'hF0F0, 32'hFF00, OPC_OR, 5'd0);
    wait_drain();
    expect_resp(0, 32'h10, 1'b1, 1'b0, 1'b0);
    send(0, 32'd1, 32'd0, OPC_SLL, 5'd4);
    wait_drain();
    chk("alu_hold_in_idle", bus.alu_operandA, 32'd1);
    expect_resp(0, 32'hF800_0000, 1'b1, 1'b0, 1'b0);
    send(0, 32'h8000_0000, 32'd0, OPC_SRA, 5'd4);
    wait_drain();
    expect_resp(0, 32'h0, 1'b0, 1'b0, 1'b0);
    send(0, 32'd9, 32'd9, 5'b00110, 5'd0);
    wait_drain();

    // Requester 0 stalls its response while requester 1 waits
    bus.resp_ready_0 = 1'b0;
    expect_resp(0, 32'd300, 1'b1, 1'b0, 1'b0);
    expect_resp(1, 32'h0F, 1'b1, 1'b0, 1'b0);
    send(0, 32'd100, 32'd200, OPC_ADD, 5'd0);
    bus.req_opA_1 = 32'hFF; bus.req_opB_1 = 32'h0F; bus.req_opcode_1 = OPC_AND;
    bus.req_shamt_1 = 5'd0; bus.req_valid_1 = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("hold_ready_1", 32'(bus.req_ready_1), 32'd0);
      chk("hold_result_0", bus.resp_result_0, 32'd300);
    end
    @(posedge clk); #1;
    bus.resp_ready_0 = 1'b1;
    @(negedge clk);
    chk("release_resp_cycle_ready_1", 32'(bus.req_ready_1), 32'd0);
    @(negedge clk);
    chk("release_idle_ready_1", 32'(bus.req_ready_1), 32'd1);
    @(posedge clk); #1;
    bus.req_valid_1 = 1'b0;
    wait_drain();

    // Requester 0 completes last, then its next op is killed by reset in EXEC
    expect_resp(0, 32'd2, 1'b0, 1'b0, 1'b0);
    send(0, 32'd1, 32'd1, OPC_ADD, 5'd0);
    wait_drain();
    send(0, 32'd50, 32'd50, OPC_ADD, 5'd0);
    do_reset();
    @(negedge clk);
    chk("post_rst_resp_valid_0", 32'(bus.resp_valid_0), 32'd0);
    chk("post_rst_resp_valid_1", 32'(bus.resp_valid_1), 32'd0);
    repeat (4) @(negedge clk);
    chk("no_discarded_resp_0", 32'(bus.resp_valid_0), 32'd0);
    @(posedge clk); #1;

    // After reset requester 0 has priority again
    expect_resp(0, 32'hFFFF_FFFF, 1'b1, 1'b1, 1'b0);
    expect_resp(1, 32'h8000_0000, 1'b1, 1'b0, 1'b1);
    fork
      send(0, 32'd1, 32'd2, OPC_SUB, 5'd0);
      send(1, 32'h7FFF_FFFF, 32'd1, OPC_ADD, 5'd0);
    join
    wait_drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, errors);
    $finish;
  end

endmodule
